// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit scheduler and its arbiter.
package uart_pkg;

  localparam int UART_DATA_W          = 8;
  localparam int START_HOLD_DEFAULT   = 16;
  localparam int BUSY_TIMEOUT_DEFAULT = 1024;

  typedef enum logic [1:0] {
    SCHED_IDLE      = 2'd0,
    SCHED_START     = 2'd1,
    SCHED_WAIT_BUSY = 2'd2,
    SCHED_WAIT_DONE = 2'd3
  } sched_state_e;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the last
// granted index and wraps, producing a one-hot grant plus its index.
module uart_rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0] last_grant_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             any_o
);

  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    cand_idx    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand_idx = IDX_W'((int'(last_grant_i) + i) % N_REQ);
      if (!any_o && valid_i[cand_idx]) begin
        any_o             = 1'b1;
        grant_o[cand_idx] = 1'b1;
        grant_idx_o       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter between N_REQ byte sources.
// Optional busy-rise watchdog enabled by defining UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int N_REQ        = 2,
  parameter int START_HOLD   = START_HOLD_DEFAULT,
  parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEFAULT
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [N_REQ-1:0]           i_req_valid,
  input  logic [UART_DATA_W*N_REQ-1:0] i_req_data,
  output logic [N_REQ-1:0]           o_req_ready,
  output logic                       o_tx_start,
  output logic [UART_DATA_W-1:0]     o_tx_data,
  input  logic                       i_tx_busy,
  output logic [$clog2(N_REQ)-1:0]   o_grant_id,
  output logic                       o_active,
  output logic                       o_err_timeout
);

  localparam int GID_W  = $clog2(N_REQ);
  localparam int HOLD_W = $clog2(START_HOLD + 1);

  sched_state_e           state_q, state_d;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
  logic [GID_W-1:0]       last_grant_q, last_grant_d;
  logic [GID_W-1:0]       grant_id_q, grant_id_d;
  logic                   busy_meta_q, busy_s_q;

  logic [N_REQ-1:0]       arb_valid;
  logic [N_REQ-1:0]       arb_grant;
  logic [GID_W-1:0]       arb_idx;
  logic                   arb_any;
  logic [UART_DATA_W-1:0] sel_data;
  logic [N_REQ-1:0]       req_ready;

`ifdef UART_TX_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(BUSY_TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_q, err_d;
`endif

  // busy comes from the baud-clock domain, so nothing looks at it unsynchronised
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_meta_q <= 1'b0;
      busy_s_q    <= 1'b0;
    end else begin
      busy_meta_q <= i_tx_busy;
      busy_s_q    <= busy_meta_q;
    end
  end

  assign arb_valid = (state_q == SCHED_IDLE && !busy_s_q) ? i_req_valid : '0;

  uart_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (GID_W)
  ) u_arb (
    .valid_i      (arb_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (arb_grant),
    .grant_idx_o  (arb_idx),
    .any_o        (arb_any)
  );

  assign sel_data = i_req_data[int'(arb_idx)*UART_DATA_W +: UART_DATA_W];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= SCHED_IDLE;
      hold_cnt_q   <= '0;
      tx_data_q    <= '0;
      last_grant_q <= GID_W'(N_REQ - 1);
      grant_id_q   <= '0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      tx_data_q    <= tx_data_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
    end
  end

`ifdef UART_TX_SCHED_TIMEOUT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    tx_data_d    = tx_data_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    req_ready    = '0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    to_cnt_d     = '0;
    err_d        = err_q;
`endif
    case (state_q)
      SCHED_IDLE: begin
        hold_cnt_d = '0;
        if (arb_any) begin
          req_ready    = arb_grant;
          tx_data_d    = sel_data;
          last_grant_d = arb_idx;
          grant_id_d   = arb_idx;
          state_d      = SCHED_START;
        end
      end
      SCHED_START: begin
        // a fast transmitter may already report busy when the start pulse ends
        if (hold_cnt_q == HOLD_W'(START_HOLD - 1)) begin
          hold_cnt_d = '0;
          state_d    = busy_s_q ? SCHED_WAIT_DONE : SCHED_WAIT_BUSY;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      SCHED_WAIT_BUSY: begin
        if (busy_s_q) begin
          state_d = SCHED_WAIT_DONE;
`ifdef UART_TX_SCHED_TIMEOUT_EN
        end else if (to_cnt_q == TO_W'(BUSY_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = SCHED_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
`endif
        end
      end
      SCHED_WAIT_DONE: begin
        if (!busy_s_q) begin
          state_d = SCHED_IDLE;
        end
      end
      default: state_d = SCHED_IDLE;
    endcase
  end

  assign o_req_ready = req_ready;
  assign o_tx_start  = (state_q == SCHED_START);
  assign o_tx_data   = tx_data_q;
  assign o_grant_id  = grant_id_q;
  assign o_active    = (state_q != SCHED_IDLE);

`ifdef UART_TX_SCHED_TIMEOUT_EN
  assign o_err_timeout = err_q;
`else
  assign o_err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with two requesters; frames are table-driven,
// multi-cycle corner cases (reset, external busy, valid drop, timeout) are hand-written.
module tb_uart_tx_sched;

  logic        clk;
  logic        rstN;
  logic [1:0]  reqValid;
  logic [15:0] reqData;
  logic [1:0]  reqReady;
  logic        txStart;
  logic [7:0]  txData;
  logic        txBusy;
  logic        grantId;
  logic        active;
  logic        errTimeout;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] valid;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] expReady;
    logic       expId;
    logic [7:0] expData;
  } vec_t;

  vec_t vecs[6];

  uart_tx_sched #(
    .N_REQ        (2),
    .START_HOLD   (16),
    .BUSY_TIMEOUT (1024)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rstN),
    .i_req_valid   (reqValid),
    .i_req_data    (reqData),
    .o_req_ready   (reqReady),
    .o_tx_start    (txStart),
    .o_tx_data     (txData),
    .i_tx_busy     (txBusy),
    .o_grant_id    (grantId),
    .o_active      (active),
    .o_err_timeout (errTimeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [1:0] valid, input logic [7:0] d0, input logic [7:0] d1);
    reqValid = valid;
    reqData  = {d1, d0};
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // one full frame: offer, check grant, count the start pulse, model busy, return to idle
  task automatic runFrame(input vec_t v);
    int startCnt;
    int extraReady;
    int guard;
    applyStimulus(v.valid, v.d0, v.d1);
    #1;
    checkOutput("ready", 32'(reqReady), 32'(v.expReady));
    @(posedge clk);
    #1;
    reqValid = reqValid & ~v.expReady;
    checkOutput("txdata", 32'(txData), 32'(v.expData));
    checkOutput("grantid", 32'(grantId), 32'(v.expId));
    checkOutput("active", 32'(active), 32'd1);
    startCnt   = 0;
    extraReady = 0;
    guard      = 0;
    @(negedge clk);
    while (txStart && guard < 100) begin
      startCnt++;
      if (reqReady != 2'b00) extraReady++;
      @(negedge clk);
      guard++;
    end
    checkOutput("startlen", 32'(startCnt), 32'd16);
    txBusy = 1'b1;
    repeat (50) begin
      if (reqReady != 2'b00) extraReady++;
      @(negedge clk);
    end
    checkOutput("datastable", 32'(txData), 32'(v.expData));
    txBusy = 1'b0;
    guard  = 0;
    while (active && guard < 20) begin
      if (reqReady != 2'b00) extraReady++;
      @(negedge clk);
      guard++;
    end
    checkOutput("backidle", 32'(active), 32'd0);
    checkOutput("extraready", 32'(extraReady), 32'd0);
    reqValid = 2'b00;
  endtask

  initial begin
    int readySeen;
    vec_t v;

    vecs[0] = '{2'b01, 8'h41, 8'h00, 2'b01, 1'b0, 8'h41};
    vecs[1] = '{2'b11, 8'h30, 8'h31, 2'b10, 1'b1, 8'h31};
    vecs[2] = '{2'b11, 8'h30, 8'h31, 2'b01, 1'b0, 8'h30};
    vecs[3] = '{2'b11, 8'h30, 8'h31, 2'b10, 1'b1, 8'h31};
    vecs[4] = '{2'b10, 8'h00, 8'h55, 2'b10, 1'b1, 8'h55};
    vecs[5] = '{2'b01, 8'hA5, 8'h00, 2'b01, 1'b0, 8'hA5};

    rstN   = 1'b0;
    txBusy = 1'b0;
    applyStimulus(2'b00, 8'h00, 8'h00);
    #12;
    checkOutput("rst_ready", 32'(reqReady), 32'd0);
    checkOutput("rst_start", 32'(txStart), 32'd0);
    checkOutput("rst_data", 32'(txData), 32'd0);
    checkOutput("rst_active", 32'(active), 32'd0);
    checkOutput("rst_err", 32'(errTimeout), 32'd0);
    checkOutput("rst_gid", 32'(grantId), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      runFrame(vecs[i]);
    end

    // valid withdrawn before the edge that would have transferred it
    applyStimulus(2'b01, 8'h66, 8'h00);
    #1;
    checkOutput("drop_ready", 32'(reqReady), 32'd1);
    #2;
    reqValid = 2'b00;
    @(posedge clk);
    #1;
    checkOutput("drop_active", 32'(active), 32'd0);
    checkOutput("drop_start", 32'(txStart), 32'd0);
    @(negedge clk);
    checkOutput("drop_idle", 32'(active), 32'd0);

    // transmitter busy on its own: no ready until the synchronised busy falls
    txBusy = 1'b1;
    repeat (3) @(negedge clk);
    applyStimulus(2'b01, 8'h77, 8'h00);
    readySeen = 0;
    repeat (10) begin
      @(negedge clk);
      if (reqReady != 2'b00) readySeen++;
    end
    checkOutput("extbusy_ready", 32'(readySeen), 32'd0);
    txBusy = 1'b0;
    @(negedge clk);
    checkOutput("extbusy_sync", 32'(reqReady), 32'd0);
    @(negedge clk);
    v = '{2'b01, 8'h77, 8'h00, 2'b01, 1'b0, 8'h77};
    runFrame(v);

    // reset in WAIT_DONE, then requester 0 must win again
    applyStimulus(2'b11, 8'h30, 8'h31);
    #1;
    checkOutput("midrst_ready", 32'(reqReady), 32'd2);
    @(posedge clk);
    #1;
    reqValid = 2'b00;
    repeat (17) @(negedge clk);
    txBusy = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("midrst_inframe", 32'(active), 32'd1);
    rstN   = 1'b0;
    txBusy = 1'b0;
    #1;
    checkOutput("midrst_active", 32'(active), 32'd0);
    checkOutput("midrst_start", 32'(txStart), 32'd0);
    checkOutput("midrst_data", 32'(txData), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    repeat (3) @(negedge clk);
    v = '{2'b11, 8'h30, 8'h31, 2'b01, 1'b0, 8'h30};
    runFrame(v);

    // busy never rises after the start pulse
    applyStimulus(2'b10, 8'h00, 8'h5A);
    #1;
    checkOutput("to_ready", 32'(reqReady), 32'd2);
    @(posedge clk);
    #1;
    reqValid = 2'b00;
    repeat (1100) @(negedge clk);
    checkOutput("to_start", 32'(txStart), 32'd0);
`ifdef UART_TX_SCHED_TIMEOUT_EN
    checkOutput("to_err", 32'(errTimeout), 32'd1);
    checkOutput("to_idle", 32'(active), 32'd0);
    v = '{2'b01, 8'h12, 8'h00, 2'b01, 1'b0, 8'h12};
    runFrame(v);
    checkOutput("to_sticky", 32'(errTimeout), 32'd1);
`else
    checkOutput("to_err", 32'(errTimeout), 32'd0);
    checkOutput("to_stuck", 32'(active), 32'd1);
    txBusy = 1'b1;
    repeat (5) @(negedge clk);
    txBusy = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("to_recover", 32'(active), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
